// File: rtl/spd_ramp_pkg.sv
// Shared types and constants for the dual-channel speed ramp.
package spd_ramp_pkg;

  typedef logic signed [11:0] spd_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP
  } ramp_state_t;

  localparam spd_t SPD_MAX = 12'sd2047;
  localparam spd_t SPD_MIN = -12'sd2047;

  // -2048 has no positive mirror, so it is pulled in to -2047 on capture.
  function automatic spd_t sat_tgt(input spd_t v);
    if (v[11] && (v[10:0] == '0)) begin
      return SPD_MIN;
    end
    return v;
  endfunction

endpackage

// File: rtl/spd_step.sv
// One slew-limited step of a single speed channel toward its aim point.
module spd_step
  import spd_ramp_pkg::*;
(
  input  spd_t       cur,
  input  spd_t       tgt,
  input  logic [7:0] step,
  output spd_t       nxt
);

  logic signed [12:0] diff;
  logic signed [12:0] mag;
  logic signed [12:0] stp;
  logic signed [12:0] sum;

  // 13-bit difference cannot overflow for 12-bit operands; result is clamped to the symmetric range.
  always_comb begin
    diff = $signed({tgt[11], tgt}) - $signed({cur[11], cur});
    mag  = diff[12] ? -diff : diff;
    stp  = $signed({5'b0_0000, step});
    sum  = $signed({cur[11], cur}) + (diff[12] ? -stp : stp);
    if (mag <= stp) begin
      nxt = tgt;
    end else if (sum > 13'sd2047) begin
      nxt = SPD_MAX;
    end else if (sum < -13'sd2047) begin
      nxt = SPD_MIN;
    end else begin
      nxt = sum[11:0];
    end
  end

endmodule

// File: rtl/spd_ramp.sv
// Dual-channel slew-rate limiter feeding the motor driver speed inputs.
module spd_ramp
  import spd_ramp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1024,
  parameter int unsigned STEP     = 16,
  parameter int unsigned BRK_STEP = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic estop,
  input  logic tgt_vld,
  input  spd_t lft_tgt,
  input  spd_t rght_tgt,
  output spd_t lft_spd,
  output spd_t rght_spd,
  output logic at_tgt,
  output logic busy
);

  localparam int unsigned    CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]     STEP_S   = 8'(STEP);
  localparam logic [7:0]     BRK_S    = 8'(BRK_STEP);

  logic [CW-1:0] cnt;
  logic          tick;
  spd_t          lft_t;
  spd_t          rght_t;
  ramp_state_t   state;

  logic          stopping;
  logic [7:0]    step_sel;
  spd_t          lft_aim;
  spd_t          rght_aim;
  spd_t          lft_nxt;
  spd_t          rght_nxt;
  logic          match;
  logic          zero;

  // Aim at the latched targets while ramping, at zero while braking.
  always_comb begin
    tick     = (cnt == CNT_LAST);
    stopping = (state == STOP);
    step_sel = stopping ? BRK_S : STEP_S;
    lft_aim  = stopping ? '0 : lft_t;
    rght_aim = stopping ? '0 : rght_t;
    match    = (lft_spd == lft_t) && (rght_spd == rght_t);
    zero     = (lft_spd == '0) && (rght_spd == '0);
  end

  spd_step u_step_lft (
    .cur  (lft_spd),
    .tgt  (lft_aim),
    .step (step_sel),
    .nxt  (lft_nxt)
  );

  spd_step u_step_rght (
    .cur  (rght_spd),
    .tgt  (rght_aim),
    .step (step_sel),
    .nxt  (rght_nxt)
  );

  // Free-running ramp tick divider, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

  // Control FSM with target latches and registered speed/status outputs.
  // Equality checks use the pre-edge target registers, so a target captured on a tick
  // edge only influences the following tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lft_spd  <= '0;
      rght_spd <= '0;
      lft_t    <= '0;
      rght_t   <= '0;
      at_tgt   <= 1'b0;
      busy     <= 1'b0;
    end else if (estop) begin
      state    <= IDLE;
      lft_spd  <= '0;
      rght_spd <= '0;
      lft_t    <= '0;
      rght_t   <= '0;
      at_tgt   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (tgt_vld) begin
        lft_t  <= sat_tgt(lft_tgt);
        rght_t <= sat_tgt(rght_tgt);
      end
      unique case (state)
        IDLE: begin
          if (en) begin
            if (match) begin
              state  <= HOLD;
              at_tgt <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state  <= RAMP;
              at_tgt <= 1'b0;
              busy   <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (!en) begin
            state  <= STOP;
            at_tgt <= 1'b0;
            busy   <= 1'b1;
          end else if (tick) begin
            lft_spd  <= lft_nxt;
            rght_spd <= rght_nxt;
          end else if (match) begin
            state  <= HOLD;
            at_tgt <= 1'b1;
            busy   <= 1'b0;
          end
        end
        HOLD: begin
          if (!en) begin
            state  <= STOP;
            at_tgt <= 1'b0;
            busy   <= 1'b1;
          end else if (!match) begin
            state  <= RAMP;
            at_tgt <= 1'b0;
            busy   <= 1'b1;
          end
        end
        STOP: begin
          if (en) begin
            state  <= RAMP;
            at_tgt <= 1'b0;
            busy   <= 1'b1;
          end else if (tick) begin
            lft_spd  <= lft_nxt;
            rght_spd <= rght_nxt;
          end else if (zero) begin
            state  <= IDLE;
            at_tgt <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          at_tgt <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spd_ramp.md
Name: spd_ramp

Overview:
- Dual-channel slew-rate limiter between the steering/command logic and the motor driver.
- Accepts left/right signed speed targets and moves lft_spd/rght_spd toward them by at most a fixed step per ramp tick.
- Its outputs are the lft_spd/rght_spd inputs of the motor driver. They are never allowed to step abruptly, except on emergency stop.
- Provides a graceful ramp-to-zero on disable and an immediate zero on estop.

Parameters:
- TICK_DIV, 1024: clocks per ramp update, >=2.
- STEP, 16: max per-tick change of each channel while ramping, 1..255.
- BRK_STEP, 32: max per-tick change toward zero in STOP state, 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  motion enable, level.
- estop  in  1  emergency stop, level.
- tgt_vld  in  1  one-cycle strobe; capture lft_tgt/rght_tgt.
- lft_tgt  in  12 signed  left target speed.
- rght_tgt  in  12 signed  right target speed.
- lft_spd  out  12 signed  ramped left speed, registered.
- rght_spd  out  12 signed  ramped right speed, registered.
- at_tgt  out  1  both outputs equal latched targets while en=1.
- busy  out  1  state is RAMP or STOP.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: lft_spd=0, rght_spd=0, latched targets=0, tick counter=0, state=IDLE, at_tgt=0, busy=0.
- A rst asserted mid-ramp takes effect on that edge: outputs go to 0, with no ramp-down.
- Tick counter cnt:
  - Free-running 0..TICK_DIV-1. It wraps, and is cleared only by rst.
  - tick = (cnt==TICK_DIV-1), combinational. Channel updates occur on the clock edge where tick=1.
- Target capture:
  - On tgt_vld, targets are registered at the edge, in any state.
  - Value -2048 (12'h800) is saturated to -2047 on capture, so the legal range is symmetric.
  - If tgt_vld and tick occur in the same cycle, the step uses the previously latched targets. The new targets apply from the next tick.
- Step rule, per channel:
  - diff = tgt - spd, computed 13-bit signed (range -4094..+4094; no overflow).
  - If |diff| <= S then spd <= tgt; else spd <= spd + sign(diff)*S.
  - S = STEP in RAMP; S = BRK_STEP in STOP, where tgt is treated as 0.
  - A result never exceeds +/-2047.
  - Both channels step on the same tick, independently.
- States:
  - IDLE: outputs hold (0 after reset/STOP).
    - en=1 and estop=0 and (latched tgt != outputs) -> RAMP.
    - en=1 and already equal -> HOLD.
  - RAMP: step toward targets on each tick.
    - Both channels equal to targets after an update -> HOLD on the next edge.
  - HOLD: outputs constant; at_tgt=1.
    - A new tgt_vld with differing values -> RAMP.
  - STOP: entered from RAMP/HOLD when en=0. Step toward 0 with BRK_STEP each tick.
    - Both channels 0 -> IDLE.
    - If en returns to 1 while in STOP -> RAMP; ramping resumes from the current outputs.
- estop:
  - Has priority over everything except rst.
  - While estop=1: next edge forces lft_spd=rght_spd=0, latched targets=0, state=IDLE.
  - Stays IDLE until estop=0. Targets must be re-sent after release.
- at_tgt: registered; 1 only in HOLD. busy=1 in RAMP and STOP.
- Priority order: rst > estop > en-drop (STOP) > tgt_vld/tick.

Decomposition:
- Shared package spd_ramp_pkg:
  - Typedef spd_t (logic signed [11:0]).
  - Enum ramp_state_t {IDLE, RAMP, HOLD, STOP}.
  - Constants SPD_MAX=12'sd2047 and SPD_MIN=-12'sd2047.
- Sub-module spd_step:
  - Combinational function of (cur, tgt, step) returning next speed. Implements the 13-bit diff and clamp.
  - Instantiated once per channel.
- Top holds the counter, FSM, target registers and output registers.

Test Plan:
1. Reset: rst=1 for 2 clocks with nonzero targets pending -> lft_spd=rght_spd=0, at_tgt=0, busy=0; cnt restarts at 0 after release.
2. Basic ramp, TICK_DIV=4, STEP=16, en=1, tgt_vld lft=100, rght=-40:
   - Ticks 1/2/3 -> rght -16/-32/-40.
   - lft 16,32,...,96, then 100 on tick 7.
   - at_tgt=1 one edge after tick 7.
3. Reversal and extremes:
   - From lft=100, target -100 -> crosses 0, reaches -100 on tick 13.
   - From 2047, target 12'h800 -> captured -2047; 4094-wide diff steps by exactly -16 with no wrap.
4. Disable mid-ramp, BRK_STEP=32: en=0 at lft=80, rght=-50 -> STOP.
   - lft 48,16,0 and rght -18,0.
   - Then IDLE, busy=0.
   - en=1 again -> RAMP resumes toward the latched targets.
5. estop in RAMP: outputs 0 on the next edge, state IDLE; tgt_vld while estop=1 has no effect on outputs.
6. Same-cycle tgt_vld and tick: step uses the old target; the new target is applied from the next tick.
